keypad_matrix_emulator: RTL and testbench
=========================================

Name: keypad_matrix_emulator

Overview:
- Synthesizable model of a 4x4 membrane keypad: the switch-matrix end of the row/col interface driven by keyboard_scan.
- Observes the scanner's row drive and returns col levels as a closed key contact would, including contact bounce on press and release.
- Used for on-board loopback (scanner to emulator, no physical keypad) and as the stimulus source in scanner/filter benches.
- Commanded by a press/release request handshake carrying a 4-bit key code.

Parameters:
- BOUNCE_CYCLES, 500000, length of each bounce window in clk cycles (10 ms at 50 MHz).
- TOGGLE_DIV, 4096, clk cycles between contact re-evaluations inside a bounce window.
- LFSR_SEED, 16'hACE1, non-zero reset seed of the bounce LFSR.

Ports:
- clk  input  1  system clock, 50 MHz.
- rstn  input  1  asynchronous active-low reset.
- row  input  4  scanner row drive, active-low; one row low at a time.
- col  output  4  column return to scanner, active-low; idle 4'b1111 (pull-up model).
- key_code  input  4  key to press; row index = key_code[3:2], col index = key_code[1:0], key index = row*4+col.
- press_req  input  1  single-cycle request to press key_code.
- release_req  input  1  single-cycle request to release the held key.
- busy  output  1  high while in either bounce state.
- pressed  output  1  high from press acceptance until release bounce ends.

Behaviour:
- Reset is asynchronous, active-low; clk is the only clock.
  - Reset forces state IDLE, contact=0, latched code=0, LFSR=LFSR_SEED, counters=0, busy=0, pressed=0, col=4'b1111.
- Contact path, combinational (models wire through the switch):
  - col[c] = contact ? row[r] : 1 for c = latched col index.
  - All other col bits = 1.
  - Zero-cycle latency from row to col.
- Contact is a registered bit.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk in any state.
- State IDLE:
  - press_req=1: latch key_code; go PRESS_BOUNCE. Bounce counter and divider clear to 0; pressed=1, busy=1 from the next cycle.
  - release_req is ignored.
- State PRESS_BOUNCE:
  - Every TOGGLE_DIV cycles, contact <= lfsr[0].
  - After BOUNCE_CYCLES cycles, contact <= 1 and go HELD; busy=0.
- State HELD:
  - contact=1 steady.
  - release_req=1: go RELEASE_BOUNCE; counters clear; busy=1.
- State RELEASE_BOUNCE:
  - Same toggling as PRESS_BOUNCE.
  - At the end, contact <= 0 and go IDLE; pressed=0, busy=0.
- Requests outside their accepting state are dropped; no queueing.
- key_code is sampled only on an accepted press. Changes while pressed have no effect.
- press_req and release_req high together in IDLE: press wins. In HELD: release wins.
- Bounce counter width: clog2(BOUNCE_CYCLES+1). Divider width: clog2(TOGGLE_DIV).
- The bounce counter saturates at BOUNCE_CYCLES; no wrap.
- Reset mid-bounce or while held: immediate release, col=4'b1111 asynchronously.

Optional Feature:
- KEYPAD_BOUNCE_EN defined: bounce behaviour as above.
- KEYPAD_BOUNCE_EN undefined:
  - No LFSR.
  - The contact goes to 1 (press) or 0 (release) on the first cycle of the bounce state, then holds steady for the rest of the BOUNCE_CYCLES window.
  - State timing and busy/pressed are unchanged.

Decomposition:
- Shared package keypad_pkg:
  - state enum (IDLE, PRESS_BOUNCE, HELD, RELEASE_BOUNCE)
  - KEY_ROWS=4, KEY_COLS=4
  - LFSR tap constant
  - key-code field positions, also used by keyboard_scan and onehot2binary benches
- One natural sub-module: bounce_lfsr, with clk, rstn, seed, and a 1-bit output.

Test Plan:
- Reset with row=4'b1110 -> col=4'b1111, busy=0, pressed=0. Assert rstn low mid-HELD -> col=4'b1111 within the same cycle.
- key_code=4'd6 (row1,col2), press_req, bounce disabled, BOUNCE_CYCLES=100:
  - row=4'b1101 -> col=4'b1011 from cycle 1.
  - row=4'b1110 -> col=4'b1111.
  - busy falls at cycle 101.
- key_code=4'd15, bounce enabled, TOGGLE_DIV=8, BOUNCE_CYCLES=200, row held 4'b0111:
  - col[3] toggles only on 8-cycle boundaries during the window.
  - col[3]=0 steady after cycle 200.
- release_req while HELD with key 0, row=4'b1110:
  - col[0] returns to 1 at window end.
  - pressed falls with busy.
- press_req during PRESS_BOUNCE with a different code -> ignored; the original column is still driven.
- Loopback keyboard_scan, then key_filter, then onehot2binary:
  - press key 9 -> decoded binary settles to 4'd9.
  - release -> key_deb returns to 16'h0000.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: FSM states, matrix size, bounce LFSR taps and key-code field layout.
// The key-code field helpers are shared with keyboard_scan and the onehot2binary benches.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        PRESS_BOUNCE   = 2'd1,
        HELD           = 2'd2,
        RELEASE_BOUNCE = 2'd3
    } key_state_t;

    localparam int KEY_ROWS   = 4;
    localparam int KEY_COLS   = 4;
    localparam int KEY_CODE_W = 4;

    // key_code = {row[1:0], col[1:0]}, key index = row*4 + col
    localparam int KEY_ROW_LSB = 2;
    localparam int KEY_ROW_W   = 2;
    localparam int KEY_COL_LSB = 0;
    localparam int KEY_COL_W   = 2;

    // Fibonacci taps 16,14,13,11 as bit positions of a right-shifting register
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [KEY_ROW_W-1:0] key_row(input logic [KEY_CODE_W-1:0] code);
        return code[KEY_ROW_LSB +: KEY_ROW_W];
    endfunction

    function automatic logic [KEY_COL_W-1:0] key_col(input logic [KEY_CODE_W-1:0] code);
        return code[KEY_COL_LSB +: KEY_COL_W];
    endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// Free-running 16-bit Fibonacci LFSR supplying the random contact level during bounce.
// Only built when KEYPAD_BOUNCE_EN is defined.
`ifdef KEYPAD_BOUNCE_EN
module bounce_lfsr
    import keypad_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic [LFSR_W-1:0] seed,
    output logic              rnd_bit
);

    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr <= seed;
        end else begin
            lfsr <= {^(lfsr & LFSR_TAPS), lfsr[LFSR_W-1:1]};
        end
    end

    assign rnd_bit = lfsr[0];

endmodule
`endif

// File: rtl/keypad_matrix_emulator.sv
// 4x4 membrane keypad model: returns the scanner's row drive on the held key's column.
// Define KEYPAD_BOUNCE_EN for random contact bounce; otherwise the contact switches cleanly.
module keypad_matrix_emulator
    import keypad_pkg::*;
#(
    parameter int          BOUNCE_CYCLES = 500000,
    parameter int          TOGGLE_DIV    = 4096,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [KEY_ROWS-1:0]   row,
    output logic [KEY_COLS-1:0]   col,
    input  logic [KEY_CODE_W-1:0] key_code,
    input  logic                  press_req,
    input  logic                  release_req,
    output logic                  busy,
    output logic                  pressed
);

    localparam int               CNT_W   = $clog2(BOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BOUNCE_CYCLES);

    key_state_t            state, state_next;
    logic                  contact, contact_next;
    logic [KEY_CODE_W-1:0] code, code_next;
    logic [CNT_W-1:0]      cnt, cnt_next;

`ifdef KEYPAD_BOUNCE_EN
    localparam int               DIV_W    = (TOGGLE_DIV > 1) ? $clog2(TOGGLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TOGGLE_DIV - 1);

    logic [DIV_W-1:0] div, div_next;
    logic             rnd_bit;

    bounce_lfsr u_lfsr (
        .clk     (clk),
        .rstn    (rstn),
        .seed    (LFSR_SEED),
        .rnd_bit (rnd_bit)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div <= '0;
        end else begin
            div <= div_next;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{LFSR_SEED, TOGGLE_DIV};
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            contact <= 1'b0;
            code    <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_next;
            contact <= contact_next;
            code    <= code_next;
            cnt     <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        contact_next = contact;
        code_next    = code;
        cnt_next     = cnt;
`ifdef KEYPAD_BOUNCE_EN
        div_next     = div;
`endif
        case (state)
            IDLE: begin
                if (press_req) begin
                    code_next  = key_code;
                    cnt_next   = '0;
`ifdef KEYPAD_BOUNCE_EN
                    div_next   = '0;
`endif
                    state_next = PRESS_BOUNCE;
                end
            end
            PRESS_BOUNCE, RELEASE_BOUNCE: begin
                // The window spans counter values 0..BOUNCE_CYCLES; the final edge settles the contact
                if (cnt == CNT_MAX) begin
                    contact_next = (state == PRESS_BOUNCE);
                    state_next   = (state == PRESS_BOUNCE) ? HELD : IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
`ifdef KEYPAD_BOUNCE_EN
                    if (div == DIV_LAST) begin
                        div_next     = '0;
                        contact_next = rnd_bit;
                    end else begin
                        div_next = div + DIV_W'(1);
                    end
`else
                    if (cnt == '0) begin
                        contact_next = (state == PRESS_BOUNCE);
                    end
`endif
                end
            end
            HELD: begin
                contact_next = 1'b1;
                if (release_req) begin
                    cnt_next   = '0;
`ifdef KEYPAD_BOUNCE_EN
                    div_next   = '0;
`endif
                    state_next = RELEASE_BOUNCE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Combinational path through the closed switch: no latency from row to col
    always_comb begin
        col = '1;
        col[key_col(code)] = contact ? row[key_row(code)] : 1'b1;
    end

    assign busy    = (state == PRESS_BOUNCE) || (state == RELEASE_BOUNCE);
    assign pressed = (state != IDLE);

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for keypad_matrix_emulator with BOUNCE_CYCLES=100 and TOGGLE_DIV=8.
// Bounce-specific expectations are selected by KEYPAD_BOUNCE_EN, matching the RTL build.
module tb_keypad_matrix_emulator;

    localparam int BC      = 100;
    localparam int TD      = 8;
    localparam int MAX_CYC = 400;

    logic       clk;
    logic       rstn;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       press_req;
    logic       release_req;
    logic       busy;
    logic       pressed;

    int checks   = 0;
    int failures = 0;

    keypad_matrix_emulator #(
        .BOUNCE_CYCLES (BC),
        .TOGGLE_DIV    (TD),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .row         (row),
        .col         (col),
        .key_code    (key_code),
        .press_req   (press_req),
        .release_req (release_req),
        .busy        (busy),
        .pressed     (pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request; returns #1 after the edge that samples it (cycle 0 of any window)
    task automatic apply_stimulus(input logic [3:0] code, input logic p, input logic r);
        key_code    = code;
        press_req   = p;
        release_req = r;
        tick();
        press_req   = 1'b0;
        release_req = 1'b0;
    endtask

    // Runs until busy drops; reports the exit cycle, column changes off 8-cycle boundaries, and on-boundary changes
    task automatic wait_window(input int start, output int cyc, output int off, output int tog);
        logic [3:0] prev;
        cyc  = start;
        off  = 0;
        tog  = 0;
        prev = col;
        while (busy === 1'b1 && cyc < MAX_CYC) begin
            tick();
            cyc++;
            if (col !== prev && cyc <= BC) begin
                if (cyc >= 2 && (cyc % TD) != 0) off++;
                else tog++;
            end
            prev = col;
        end
    endtask

    task automatic scan_keys(output logic [15:0] map);
        map = '0;
        for (int r = 0; r < 4; r++) begin
            row = 4'(~(4'b0001 << r));
            #1;
            for (int c = 0; c < 4; c++) begin
                if (col[c] == 1'b0) map[r*4 + c] = 1'b1;
            end
        end
        row = 4'b1111;
        #1;
    endtask

    initial begin
        int          cyc;
        int          off;
        int          tog;
        logic [15:0] map;

        rstn        = 1'b0;
        row         = 4'b1110;
        key_code    = 4'd0;
        press_req   = 1'b0;
        release_req = 1'b0;
        #3;
        check_output("reset_col", 32'(col), 32'hF);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_pressed", 32'(pressed), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Key 6 = row 1, col 2; a second press mid-bounce must be ignored
        $display("[TB] key 6 press");
        row = 4'b1101;
        apply_stimulus(4'd6, 1'b1, 1'b0);
        check_output("k6_c0_busy", 32'(busy), 32'd1);
        check_output("k6_c0_pressed", 32'(pressed), 32'd1);
        check_output("k6_c0_col", 32'(col), 32'hF);
        tick();
`ifndef KEYPAD_BOUNCE_EN
        check_output("k6_c1_col", 32'(col), 32'hB);
`endif
        row = 4'b1110;
        #1;
        check_output("k6_other_row_col", 32'(col), 32'hF);
        apply_stimulus(4'd0, 1'b1, 1'b0);
`ifndef KEYPAD_BOUNCE_EN
        check_output("k6_ignored_press_col", 32'(col), 32'hF);
`endif
        row = 4'b1101;
        #1;
        wait_window(2, cyc, off, tog);
        check_output("k6_busy_fall_cycle", 32'(cyc), 32'd101);
        check_output("k6_off_boundary", 32'(off), 32'd0);
        check_output("k6_held_col", 32'(col), 32'hB);
        check_output("k6_held_pressed", 32'(pressed), 32'd1);

        // Release with both requests high in HELD: release wins
        apply_stimulus(4'd15, 1'b1, 1'b1);
        check_output("k6_rel_c0_busy", 32'(busy), 32'd1);
        check_output("k6_rel_c0_col", 32'(col), 32'hB);
        tick();
`ifndef KEYPAD_BOUNCE_EN
        check_output("k6_rel_c1_col", 32'(col), 32'hF);
`endif
        wait_window(1, cyc, off, tog);
        check_output("k6_rel_fall_cycle", 32'(cyc), 32'd101);
        check_output("k6_rel_pressed", 32'(pressed), 32'd0);
        check_output("k6_rel_col", 32'(col), 32'hF);

        // Key 15 with both requests in IDLE: press wins
        $display("[TB] key 15 press");
        row = 4'b0111;
        #1;
        apply_stimulus(4'd15, 1'b1, 1'b1);
        check_output("k15_c0_busy", 32'(busy), 32'd1);
        wait_window(0, cyc, off, tog);
        check_output("k15_busy_fall_cycle", 32'(cyc), 32'd101);
        check_output("k15_off_boundary", 32'(off), 32'd0);
`ifdef KEYPAD_BOUNCE_EN
        check_output("k15_bounced", 32'(tog > 0), 32'd1);
`endif
        check_output("k15_held_col", 32'(col), 32'h7);
        repeat (3) tick();
        check_output("k15_steady_col", 32'(col), 32'h7);

        // Asynchronous reset while held
        rstn = 1'b0;
        #1;
        check_output("midheld_reset_col", 32'(col), 32'hF);
        check_output("midheld_reset_pressed", 32'(pressed), 32'd0);
        check_output("midheld_reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Key 0 press and release on row 0
        $display("[TB] key 0 press/release");
        row = 4'b1110;
        #1;
        apply_stimulus(4'd0, 1'b1, 1'b0);
        wait_window(0, cyc, off, tog);
        check_output("k0_held_col", 32'(col), 32'hE);
        apply_stimulus(4'd0, 1'b0, 1'b1);
`ifndef KEYPAD_BOUNCE_EN
        tick();
        check_output("k0_rel_c1_col", 32'(col), 32'hF);
        wait_window(1, cyc, off, tog);
`else
        wait_window(0, cyc, off, tog);
`endif
        check_output("k0_rel_fall_cycle", 32'(cyc), 32'd101);
        check_output("k0_rel_col", 32'(col), 32'hF);
        check_output("k0_rel_pressed", 32'(pressed), 32'd0);
        apply_stimulus(4'd0, 1'b0, 1'b1);
        check_output("idle_release_busy", 32'(busy), 32'd0);
        check_output("idle_release_pressed", 32'(pressed), 32'd0);

        // Loopback scan of key 9 (row 2, col 1)
        $display("[TB] key 9 loopback scan");
        row = 4'b1111;
        #1;
        apply_stimulus(4'd9, 1'b1, 1'b0);
        wait_window(0, cyc, off, tog);
        scan_keys(map);
        check_output("k9_scan_map", 32'(map), 32'h0200);
        apply_stimulus(4'd9, 1'b0, 1'b1);
        wait_window(0, cyc, off, tog);
        check_output("k9_rel_fall_cycle", 32'(cyc), 32'd101);
        scan_keys(map);
        check_output("k9_rel_scan_map", 32'(map), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
